// File: rtl/riscv_pkg.sv
// Shared data-memory definitions: funct3 access-size encodings, controller FSM states, load extension.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } dmem_state_t;

  // Select the addressed lane of a word and sign/zero-extend it; reserved sizes read as 0.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] word,
                                              input logic [1:0] lo);
    logic [31:0] sh;
    sh = word >> {lo, 3'b000};
    case (f3)
      F3_B:    load_extend = {{24{sh[7]}}, sh[7:0]};
      F3_H:    load_extend = {{16{sh[15]}}, sh[15:0]};
      F3_W:    load_extend = word;
      F3_BU:   load_extend = {24'd0, sh[7:0]};
      F3_HU:   load_extend = {16'd0, sh[15:0]};
      default: load_extend = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised backing store with per-byte write enables and a registered read port.
// Latency: read data appears one cycle after rd_en; writes land on the enabling edge.
// Backpressure: none; every enabled access completes in one cycle. Contents are never reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [3:0]    byte_en,
  input  logic          rd_en,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wr_word,
  output logic [31:0]   rd_word
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-masked write and registered read of the same word index.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx][b*8 +: 8] <= wr_word[b*8 +: 8];
      end
    end
    if (rd_en) rd_word <= mem[idx];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: IDLE/ACCESS/RESP FSM, wait counter, byte-lane steering and load extension.
// Latency: request seen in IDLE at cycle 0 -> done pulse at cycle MEM_LATENCY+1.
// Backpressure: stall held from request in IDLE through ACCESS; DMEM_MISALIGN_TRAP_EN enables misalign faults.
module dmem_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_t   state_q, state_d;
  logic [3:0]    cnt_q;
  logic [31:0]   rdata_q, resp_val;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    f3_q;
  logic          wr_q, both_q;

  logic          is_byte, is_half, is_word, skip, commit;
  logic [1:0]    lo;
  logic [3:0]    byte_en;
  logic [31:0]   wr_word, rd_word;
  logic          unused_addr_hi;

  // Bits above the word index only alias the array, so they are dropped.
  assign unused_addr_hi = ^addr[31:AW+2];

  assign is_byte = (f3_q[1:0] == 2'b00);
  assign is_half = (f3_q[1:0] == 2'b01);
  assign is_word = (f3_q == F3_W);
  assign commit  = (state_q == ST_ACCESS) && (cnt_q <= 4'd1);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign lo   = addr_q[1:0];
  assign skip = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
`else
  // Misaligned halves/words are silently aligned down.
  assign lo   = is_word ? 2'b00 : (is_half ? {addr_q[1], 1'b0} : addr_q[1:0]);
  assign skip = 1'b0;
`endif

  // Byte-lane enables and replicated store data; reserved sizes enable no lanes.
  always_comb begin
    byte_en = 4'b0000;
    wr_word = wdata_q;
    if (is_byte) begin
      byte_en = 4'b0001 << lo;
      wr_word = {4{wdata_q[7:0]}};
    end else if (is_half) begin
      byte_en = lo[1] ? 4'b1100 : 4'b0011;
      wr_word = {2{wdata_q[15:0]}};
    end else if (is_word) begin
      byte_en = 4'b1111;
    end
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (clk),
    .wr_en   (commit && wr_q && !skip && !reset),
    .byte_en (byte_en),
    .rd_en   (commit && !wr_q && !skip),
    .idx     (addr_q[AW+1:2]),
    .wr_word (wr_word),
    .rd_word (rd_word)
  );

  // Next-state, stall/done and response-data selection.
  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    done     = 1'b0;
    resp_val = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (memread || memwrite) begin
          stall   = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        stall = 1'b1;
        if (cnt_q <= 4'd1) state_d = ST_RESP;
      end
      ST_RESP: begin
        done    = 1'b1;
        state_d = ST_IDLE;
        if (skip || both_q) resp_val = 32'd0;
        else if (!wr_q)     resp_val = load_extend(f3_q, rd_word, lo);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rdata = resp_val;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign fault = done && skip;
`else
  assign fault = 1'b0;
`endif

  // FSM state, wait counter and held load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      rdata_q <= resp_val;
      if (state_q == ST_IDLE && (memread || memwrite)) cnt_q <= MEM_LATENCY[3:0];
      else if (state_q == ST_ACCESS)                   cnt_q <= cnt_q - 4'd1;
    end
  end

  // Request capture in IDLE; a simultaneous read+write is treated as a store.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && (memread || memwrite)) begin
      addr_q  <= addr[AW+1:0];
      wdata_q <= wdata;
      f3_q    <= funct3;
      wr_q    <= memwrite;
      both_q  <= memread && memwrite;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl at default parameters.
// Drives requests on the falling edge and samples outputs there; cycle 0 is the request cycle.
// Expectations under DMEM_MISALIGN_TRAP_EN follow the same macro.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rdata;
  logic        stall, done, fault;

  int checks = 0;
  int errors = 0;

  int          lat;
  logic [31:0] rv;
  logic        fv;
  logic [15:0] smask;

  dmem_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .memread  (memread),
    .memwrite (memwrite),
    .addr     (addr),
    .wdata    (wdata),
    .funct3   (funct3),
    .rdata    (rdata),
    .stall    (stall),
    .done     (done),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  // Issue one request and follow it to its done pulse (bounded at 16 cycles).
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, output int l, output logic [31:0] r,
                        output logic f, output logic [15:0] sm);
    l  = -1;
    r  = 32'hxxxxxxxx;
    f  = 1'bx;
    sm = 16'd0;
    @(negedge clk);
    memread  = rd;
    memwrite = wr;
    addr     = a;
    wdata    = wd;
    funct3   = f3;
    #1;
    for (int c = 0; c < 16; c++) begin
      sm[c] = stall;
      if (done) begin
        l = c;
        r = rdata;
        f = fault;
        break;
      end
      @(negedge clk);
    end
    memread  = 1'b0;
    memwrite = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want %h", rdata, 32'd0); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (fault !== 1'b0)  begin errors++; $display("FAIL reset_fault got %b want 0", fault); end
    checks++; if (stall !== 1'b0)  begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    reset = 1'b0;
  endtask

  task automatic test_word();
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, lat, rv, fv, smask);
    checks++; if (lat !== 3)           begin errors++; $display("FAIL sw_latency got %0d want 3", lat); end
    checks++; if (smask !== 16'h0007)  begin errors++; $display("FAIL sw_stall got %h want %h", smask, 16'h0007); end
    checks++; if (rv !== 32'd0)        begin errors++; $display("FAIL sw_rdata_unchanged got %h want %h", rv, 32'd0); end
    do_req(1'b1, 1'b0, 32'h10, 32'd0, 3'b010, lat, rv, fv, smask);
    checks++; if (lat !== 3)           begin errors++; $display("FAIL lw_latency got %0d want 3", lat); end
    checks++; if (smask !== 16'h0007)  begin errors++; $display("FAIL lw_stall got %h want %h", smask, 16'h0007); end
    checks++; if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h want %h", rv, 32'hDEADBEEF); end
    checks++; if (fv !== 1'b0)         begin errors++; $display("FAIL lw_fault got %b want 0", fv); end
    @(negedge clk);
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL done_one_cycle got %b want 0", done); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold got %h want %h", rdata, 32'hDEADBEEF); end
    // 0x410 wraps onto word 4 (0x10) in a 256-word array.
    do_req(1'b1, 1'b0, 32'h410, 32'd0, 3'b010, lat, rv, fv, smask);
    checks++; if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL addr_wrap got %h want %h", rv, 32'hDEADBEEF); end
    // Reserved funct3 load returns zero.
    do_req(1'b1, 1'b0, 32'h10, 32'd0, 3'b011, lat, rv, fv, smask);
    checks++; if (rv !== 32'd0)        begin errors++; $display("FAIL reserved_load got %h want %h", rv, 32'd0); end
  endtask

  task automatic test_byte();
    do_req(1'b0, 1'b1, 32'h10, 32'h11223344, 3'b010, lat, rv, fv, smask);
    do_req(1'b0, 1'b1, 32'h13, 32'h00000080, 3'b000, lat, rv, fv, smask);
    // Reserved funct3 store must not touch the word.
    do_req(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 3'b111, lat, rv, fv, smask);
    do_req(1'b1, 1'b0, 32'h13, 32'd0, 3'b000, lat, rv, fv, smask);
    checks++; if (rv !== 32'hFFFFFF80) begin errors++; $display("FAIL lb got %h want %h", rv, 32'hFFFFFF80); end
    do_req(1'b1, 1'b0, 32'h13, 32'd0, 3'b100, lat, rv, fv, smask);
    checks++; if (rv !== 32'h00000080) begin errors++; $display("FAIL lbu got %h want %h", rv, 32'h00000080); end
    do_req(1'b1, 1'b0, 32'h10, 32'd0, 3'b010, lat, rv, fv, smask);
    checks++; if (rv !== 32'h80223344) begin errors++; $display("FAIL sb_word got %h want %h", rv, 32'h80223344); end
  endtask

  task automatic test_half();
    do_req(1'b0, 1'b1, 32'h14, 32'h00000000, 3'b010, lat, rv, fv, smask);
    do_req(1'b0, 1'b1, 32'h16, 32'h0000A5A5, 3'b001, lat, rv, fv, smask);
    do_req(1'b1, 1'b0, 32'h16, 32'd0, 3'b101, lat, rv, fv, smask);
    checks++; if (rv !== 32'h0000A5A5) begin errors++; $display("FAIL lhu got %h want %h", rv, 32'h0000A5A5); end
    do_req(1'b1, 1'b0, 32'h16, 32'd0, 3'b001, lat, rv, fv, smask);
    checks++; if (rv !== 32'hFFFFA5A5) begin errors++; $display("FAIL lh got %h want %h", rv, 32'hFFFFA5A5); end
    do_req(1'b1, 1'b0, 32'h14, 32'd0, 3'b010, lat, rv, fv, smask);
    checks++; if (rv !== 32'hA5A50000) begin errors++; $display("FAIL sh_word got %h want %h", rv, 32'hA5A50000); end
  endtask

  task automatic test_reset_abort();
    int seen_done;
    do_req(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 3'b010, lat, rv, fv, smask);
    do_req(1'b1, 1'b0, 32'h20, 32'd0, 3'b010, lat, rv, fv, smask);
    // Store request in cycle 0, reset during the first ACCESS cycle.
    @(negedge clk);
    memwrite = 1'b1; addr = 32'h20; wdata = 32'h12345678; funct3 = 3'b010;
    @(negedge clk);
    reset = 1'b1; memwrite = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL abort_rdata got %h want %h", rdata, 32'd0); end
    checks++; if (stall !== 1'b0)  begin errors++; $display("FAIL abort_stall got %b want 0", stall); end
    checks++; if (fault !== 1'b0)  begin errors++; $display("FAIL abort_fault got %b want 0", fault); end
    seen_done = 0;
    for (int c = 0; c < 5; c++) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", seen_done); end
    do_req(1'b1, 1'b0, 32'h20, 32'd0, 3'b010, lat, rv, fv, smask);
    checks++; if (rv !== 32'hCAFEF00D) begin errors++; $display("FAIL abort_mem got %h want %h", rv, 32'hCAFEF00D); end
  endtask

  task automatic test_misalign();
    do_req(1'b1, 1'b0, 32'h22, 32'd0, 3'b010, lat, rv, fv, smask);
    checks++; if (lat !== 3) begin errors++; $display("FAIL misalign_latency got %0d want 3", lat); end
`ifdef DMEM_MISALIGN_TRAP_EN
    checks++; if (fv !== 1'b1)  begin errors++; $display("FAIL misalign_fault got %b want 1", fv); end
    checks++; if (rv !== 32'd0) begin errors++; $display("FAIL misalign_rdata got %h want %h", rv, 32'd0); end
`else
    checks++; if (fv !== 1'b0)         begin errors++; $display("FAIL misalign_fault got %b want 0", fv); end
    checks++; if (rv !== 32'hCAFEF00D) begin errors++; $display("FAIL misalign_rdata got %h want %h", rv, 32'hCAFEF00D); end
`endif
  endtask

  task automatic test_back_to_back();
    do_req(1'b1, 1'b0, 32'h20, 32'd0, 3'b010, lat, rv, fv, smask);
    do_req(1'b1, 1'b1, 32'h30, 32'h00000055, 3'b010, lat, rv, fv, smask);
    checks++; if (lat !== 3)    begin errors++; $display("FAIL both_latency got %0d want 3", lat); end
    checks++; if (rv !== 32'd0) begin errors++; $display("FAIL both_rdata got %h want %h", rv, 32'd0); end
    // Issued on the cycle right after RESP.
    do_req(1'b1, 1'b0, 32'h30, 32'd0, 3'b010, lat, rv, fv, smask);
    checks++; if (lat !== 3)           begin errors++; $display("FAIL b2b_latency got %0d want 3", lat); end
    checks++; if (rv !== 32'h00000055) begin errors++; $display("FAIL both_store got %h want %h", rv, 32'h00000055); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_reset_abort();
    test_misalign();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter MEM_LATENCY, default 2, number of ACCESS-state wait cycles (legal 1..15).
REQ-002 Parameter DEPTH_WORDS, default 256, number of 32-bit words in the backing array (power of two).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 memread  input  1  load request from the decode control signals.
REQ-006 memwrite  input  1  store request from the decode control signals.
REQ-007 addr  input  32  byte address (ALU result).
REQ-008 wdata  input  32  store data (rs2 value).
REQ-009 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 rdata  output  32  load result, extended to 32 bits.
REQ-011 stall  output  1  pipeline hold; request inputs stay stable while high.
REQ-012 done  output  1  one-cycle pulse when the access completes.
REQ-013 fault  output  1  misaligned-access indication, valid with done.

Function
REQ-014 The FSM SHALL have the states IDLE, ACCESS and RESP.
REQ-015 IDLE: on memread|memwrite, latch addr/wdata/funct3/op, load wait counter with MEM_LATENCY, go to ACCESS.
REQ-016 stall SHALL be asserted combinationally in IDLE while a request is present, and throughout ACCESS; it is low in RESP.
REQ-017 ACCESS: decrement the counter each cycle; at 1, commit the store or capture the read word, then go to RESP.
REQ-018 RESP: assert done for exactly one cycle, drive rdata, return to IDLE unconditionally; a request present in RESP is ignored.
REQ-019 Latency: request in IDLE at cycle 0 -> done at cycle MEM_LATENCY+1 (cycle 3 at default).
REQ-020 memread and memwrite both high: handle as store; rdata = 0.
REQ-021 Word index = addr[log2(DEPTH_WORDS)+1:2]; upper bits ignored (address wraps).
REQ-022 Loads: B/H sign-extend, BU/HU zero-extend, lane selected by addr[1:0]/addr[1]; reserved funct3 returns 0.
REQ-023 Stores: SB writes byte lane addr[1:0], SH writes half lane addr[1], SW writes all; other bytes unchanged; reserved funct3 writes nothing.
REQ-024 rdata SHALL hold its value from RESP until the next RESP; stores leave rdata unchanged.

Reset
REQ-025 Reset SHALL force IDLE, counter 0, rdata 0, done 0, fault 0; stall follows REQ-016.
REQ-026 Reset during ACCESS before commit SHALL abort the store; array contents are not reset.

Configuration
REQ-027 Macro DMEM_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 skips the array access, rdata=0, fault=1 with done.
REQ-028 Macro undefined: fault tied 0; offending low address bits are forced to zero (aligned access).

Structure
REQ-029 Shared package riscv_pkg SHALL hold the funct3 size encodings and the FSM state enum.
REQ-030 Backing storage SHALL be a sub-module dmem_array (byte-enable write, registered read); the controller holds the FSM, counter, lane logic and extension logic.

Verification
REQ-031 SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> done at cycle 3 for each, rdata 0xDEADBEEF, stall high cycles 0-2.
REQ-032 SB 0x13 wdata 0x80 over 0x11223344 word, LB 0x13 -> rdata 0xFFFFFF80; LBU 0x13 -> 0x00000080; word reads 0x80223344.
REQ-033 SH 0x16 wdata 0xA5A5 over zero word, LHU 0x16 -> 0x0000A5A5; LH 0x16 -> 0xFFFFA5A5.
REQ-034 SW 0x20 0x12345678 with reset asserted in first ACCESS cycle, then LW 0x20 -> prior value unchanged, outputs 0 after reset.
REQ-035 LW addr 0x22: with DMEM_MISALIGN_TRAP_EN -> fault=1, rdata 0; without -> fault=0, rdata = word at 0x20.
REQ-036 memread and memwrite both high, addr 0x30 wdata 0x55 -> store performed, rdata 0, back-to-back request accepted the cycle after RESP.
